// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} muldiv_state_t;

  // True for DIV/DIVU.
  function automatic logic op_is_div(input muldiv_op_t o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  // True for the two's-complement variants MULT/DIV.
  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the 2*WIDTH accumulator.
// Multiply: acc = {partial product, unshifted multiplier}, shifted right.
// Divide:   acc = {remainder, dividend/quotient}, shifted left.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] top;
  logic [WIDTH:0] diff;

  // Next accumulator value for a single iteration.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    top      = acc[2*WIDTH-1:WIDTH-1];
    diff     = top - {1'b0, operand};
    acc_next = '0;
    if (is_div) begin
      // Remainder is always below the divisor, so top fits in WIDTH+1 bits.
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer with Hi/Lo result registers.
// Optional: define MULDIV_EARLY_EXIT_EN to let multiplies finish as soon as
// the remaining multiplier bits are all zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  muldiv_op_t         op_q;
  logic               neg_res;
  logic               neg_rem;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               early;
  logic [2*WIDTH-1:0] acc_aligned;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  localparam int unsigned SH_W = CNT_W + 1;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] rem_mask;

  // Detect an exhausted multiplier and pre-align the accumulator for FIX.
  always_comb begin
    shamt       = SH_W'(cnt) + SH_W'(1);
    rem_mask    = ~({WIDTH{1'b1}} << shamt);
    early       = !is_div && ((acc[WIDTH-1:0] & rem_mask) == '0);
    acc_aligned = acc >> shamt;
  end
`else
  // Fixed latency: never leave CALC early.
  always_comb begin
    early       = 1'b0;
    acc_aligned = acc;
  end
`endif

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    is_div    = op_is_div(op_q);
    is_signed = op_is_signed(op_q);
    a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= MD_MULT;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= muldiv_op_t'(op);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          cnt     <= CNT_W'(WIDTH - 1);
          neg_res <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_signed && a_q[WIDTH-1];
          if (is_div) begin
            operand <= b_abs;
            acc     <= {{WIDTH{1'b0}}, a_abs};
          end else begin
            operand <= a_abs;
            acc     <= {{WIDTH{1'b0}}, b_abs};
          end
          if (is_div && (b_q == '0)) begin
            div_zero <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (early) begin
            acc   <= acc_aligned;
            state <= FIX;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  // Reference model state: architectural Hi/Lo/flag after each operation.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dz;
  int          m_lat;

  muldiv_seq dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic model of one operation; updates m_* and the expected latency.
  task automatic model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
    longint      sa, sb, sq, sr;
    logic [63:0] p, uq, ur;
    logic [31:0] mag;
    int          k;
    sa  = longint'($signed(xa));
    sb  = longint'($signed(xb));
    mag = xb;
    m_lat = 34;
    case (o)
      2'd0: begin
        p = 64'(sa * sb);
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
        if (xb[31]) mag = -xb;
      end
      2'd1: begin
        p = 64'(xa) * 64'(xb);
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
      end
      2'd2: begin
        if (xb == 32'd0) begin
          m_dz = 1'b1; m_lat = 1;
        end else begin
          sq = sa / sb; sr = sa % sb;
          m_lo = sq[31:0]; m_hi = sr[31:0]; m_dz = 1'b0;
        end
      end
      default: begin
        if (xb == 32'd0) begin
          m_dz = 1'b1; m_lat = 1;
        end else begin
          uq = 64'(xa) / 64'(xb); ur = 64'(xa) % 64'(xb);
          m_lo = uq[31:0]; m_hi = ur[31:0]; m_dz = 1'b0;
        end
      end
    endcase
`ifdef MULDIV_EARLY_EXIT_EN
    if (o[1] == 1'b0) begin
      k = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
      m_lat = (3 + k < 34) ? 3 + k : 34;
    end
`else
    k = int'(mag[0]);
    if (k < 0) m_lat = 0;
`endif
  endtask

  // Issue one operation, optionally poke start while busy, and check everything.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input int poke_at);
    int lat;
    int busy_drop;
    model(o, xa, xb);
    @(negedge clock);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clock); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    check({tag, "_busy_e0"}, 64'(busy), 64'(1));
    check({tag, "_dz_clear"}, 64'(div_zero), 64'(0));
    lat = 0;
    busy_drop = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (n == poke_at) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_drop++;
      if (n + 1 == poke_at) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(m_lat));
    check({tag, "_busy_held"}, 64'(busy_drop), 64'(0));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(m_dz));
    // Start during DONE must be ignored.
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    @(posedge clock); #1;
    check({tag, "_idle_after"}, 64'(busy), 64'(0));
    check({tag, "_dz_hold"}, 64'(div_zero), 64'(m_dz));
    check({tag, "_hi_hold"}, 64'(hi), 64'(m_hi));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    checks = 0; failures = 0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; m_lat = 0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #22;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clock); reset = 1'b1;

    run_op("mult_7x-3", 2'd0, 32'd7, 32'hFFFF_FFFD, 10);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_-7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_100/7", 2'd3, 32'd100, 32'd7, 0);
    run_op("mult_pre", 2'd0, 32'h1234_5678, 32'h8765_4321, 0);
    run_op("div_by_0", 2'd2, 32'd5, 32'd0, 0);
    run_op("divu_after0", 2'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("divu_by_0", 2'd3, 32'd9, 32'd0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; ro = 2'(i);
      if (i >= 4) rb = rb >> $urandom_range(31, 20);
      run_op("rand", ro, ra, rb, $urandom_range(30, 2));
    end

    // Reset in the middle of a multiply, after an ignored start at E10.
    @(negedge clock);
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 10) start = 1'b0;
      if (n == 9) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
      end
    end
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_done", 64'(done), 64'(0));
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_dz", 64'(div_zero), 64'(0));
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clock); reset = 1'b1;
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
